// File: rtl/fft_error_poly_scatter_pkg.sv
// Shared definitions for the error-polynomial scatter block and the decap
// error-retrieval path: FSM encoding, ELP marker bytes, N1 selection and the
// codeword-position -> evaluation-RAM address table.
package fft_error_poly_scatter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_SCATTER,
      ST_DONE
   } state_t;

   localparam logic [7:0] ELP_ROOT    = 8'h00;
   localparam logic [7:0] ELP_NONROOT = 8'h01;

   localparam int FILL_LEN         = 256;
   localparam int ADDR_TABLE_DEPTH = 128;

   // Codeword length for a security level; unknown levels fall back to 128-bit.
   function automatic int n1_for(input int security);
      case (security)
         192:     return 56;
         256:     return 90;
         default: return 46;
      endcase
   endfunction

   // Position 0 maps to field element 0. Position k>=1 maps to x^(k+6) reduced
   // by x^8+x^6+x^5+x^4+1, which is the bit-reversed view of alpha^-(k-1) under
   // the 0x11D field the FFT uses. Entry k occupies bits [8k+7:8k].
   function automatic logic [8*ADDR_TABLE_DEPTH-1:0] gen_addr_table();
      logic [8*ADDR_TABLE_DEPTH-1:0] table_bits;
      logic [7:0]                    elem;
      table_bits = '0;
      elem       = 8'h80;
      for (int k = 1; k < ADDR_TABLE_DEPTH; k++) begin
         table_bits[8*k +: 8] = elem;
         elem = {elem[6:0], 1'b0} ^ (elem[7] ? 8'h71 : 8'h00);
      end
      return table_bits;
   endfunction

   localparam logic [8*ADDR_TABLE_DEPTH-1:0] ADDR_TABLE = gen_addr_table();

endpackage

// File: rtl/fft_err_addr_rom.sv
// Registered position -> evaluation-RAM address lookup. One cycle of latency,
// so callers present the index in the cycle before they need the address.
module fft_err_addr_rom
   import fft_error_poly_scatter_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] idx,
   output logic [7:0] addr
);

   // Look up the table entry for the presented index and hold it for one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr <= 8'h00;
      end else begin
         addr <= ADDR_TABLE[{idx, 3'b000} +: 8];
      end
   end

endmodule

// File: rtl/fft_error_poly_scatter.sv
// Error injector: turns an N1-byte error vector into a 256-entry ELP evaluation
// RAM image (0x00 at error positions, 0x01 elsewhere), optionally pre-filling
// the whole RAM before scattering the per-position markers.
module fft_error_poly_scatter
   import fft_error_poly_scatter_pkg::*;
#(
   parameter int PARAM_SECURITY = 128,
   parameter int FILL_ALL       = 1,
   parameter int DIN_W          = 8 * n1_for(PARAM_SECURITY)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [DIN_W-1:0] din_i,
   output logic             busy_o,
   output logic             ram_wr_o,
   output logic [7:0]       ram_addr_o,
   output logic [7:0]       ram_dout_o,
   output logic [7:0]       err_cnt_o,
   output logic             done_o
);

   localparam int         N1           = n1_for(PARAM_SECURITY);
   localparam logic [7:0] LAST_FILL    = 8'(FILL_LEN - 1);
   localparam logic [7:0] LAST_SCATTER = 8'(N1 - 1);

   state_t             state;
   logic [7:0]         k;
   logic [DIN_W-1:0]   shreg;
   logic               sel_rom;
   logic [7:0]         fill_addr;
   logic [7:0]         rom_addr;

   // The ROM sees the counter of the state cycle, so its registered output
   // lines up with the write stage that belongs to that counter value.
   fft_err_addr_rom u_addr_rom (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .idx   (k[6:0]),
      .addr  (rom_addr)
   );

   // Both address sources are registers; this only picks which stage is live.
   assign ram_addr_o = sel_rom ? rom_addr : fill_addr;

   // Sequencer: owns the counter, the error-vector shift register and every
   // registered output, so a reset anywhere clears the whole write stream.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         k          <= 8'h00;
         shreg      <= '0;
         sel_rom    <= 1'b0;
         fill_addr  <= 8'h00;
         busy_o     <= 1'b0;
         ram_wr_o   <= 1'b0;
         ram_dout_o <= 8'h00;
         err_cnt_o  <= 8'h00;
         done_o     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               ram_wr_o   <= 1'b0;
               sel_rom    <= 1'b0;
               fill_addr  <= 8'h00;
               ram_dout_o <= 8'h00;
               done_o     <= 1'b0;
               busy_o     <= 1'b0;
               if (start_i) begin
                  shreg     <= din_i;
                  err_cnt_o <= 8'h00;
                  k         <= 8'h00;
                  busy_o    <= 1'b1;
                  state     <= (FILL_ALL != 0) ? ST_FILL : ST_SCATTER;
               end
            end

            ST_FILL: begin
               ram_wr_o   <= 1'b1;
               sel_rom    <= 1'b0;
               fill_addr  <= k;
               ram_dout_o <= ELP_NONROOT;
               done_o     <= 1'b0;
               if (k == LAST_FILL) begin
                  k     <= 8'h00;
                  state <= ST_SCATTER;
               end else begin
                  k <= k + 8'h01;
               end
            end

            ST_SCATTER: begin
               ram_wr_o   <= 1'b1;
               sel_rom    <= 1'b1;
               fill_addr  <= 8'h00;
               ram_dout_o <= (shreg[7:0] == 8'h00) ? ELP_NONROOT : ELP_ROOT;
               err_cnt_o  <= err_cnt_o + {7'd0, (shreg[7:0] != 8'h00)};
               shreg      <= shreg >> 8;
               done_o     <= 1'b0;
               if (k == LAST_SCATTER) begin
                  k     <= 8'h00;
                  state <= ST_DONE;
               end else begin
                  k <= k + 8'h01;
               end
            end

            ST_DONE: begin
               ram_wr_o   <= 1'b0;
               sel_rom    <= 1'b0;
               fill_addr  <= 8'h00;
               ram_dout_o <= 8'h00;
               done_o     <= 1'b1;
               state      <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_error_poly_scatter.sv
// Directed bench for fft_error_poly_scatter: a 128-bit pre-filling instance
// driven from a vector table plus restart/reset sequences, and a 256-bit
// scatter-only instance checked against the position->address table.
module tb_fft_error_poly_scatter;

   localparam int N1A = 46;
   localparam int DWA = 8 * N1A;
   localparam int N1B = 90;
   localparam int DWB = 8 * N1B;

   logic           clk = 1'b0;
   logic           rst = 1'b1;

   logic           start_a = 1'b0;
   logic [DWA-1:0] din_a = '0;
   logic           busy_a, wr_a, done_a;
   logic [7:0]     addr_a, dout_a, err_a;

   logic           start_b = 1'b0;
   logic [DWB-1:0] din_b = '0;
   logic           busy_b, wr_b, done_b;
   logic [7:0]     addr_b, dout_b, err_b;

   int checks = 0;
   int errors = 0;

   fft_error_poly_scatter #(.PARAM_SECURITY(128), .FILL_ALL(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .din_i(din_a),
      .busy_o(busy_a), .ram_wr_o(wr_a), .ram_addr_o(addr_a),
      .ram_dout_o(dout_a), .err_cnt_o(err_a), .done_o(done_a)
   );

   fft_error_poly_scatter #(.PARAM_SECURITY(256), .FILL_ALL(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .din_i(din_b),
      .busy_o(busy_b), .ram_wr_o(wr_b), .ram_addr_o(addr_b),
      .ram_dout_o(dout_b), .err_cnt_o(err_b), .done_o(done_b)
   );

   always #5 clk = ~clk;

   // Global guard so the run can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   // Reference address for codeword position k: walk alpha^-1 steps in the
   // 0x11D field starting from 1, then bit-reverse; position 0 is element 0.
   function automatic logic [7:0] model_addr(input int k);
      logic [7:0] v;
      logic [7:0] r;
      if (k == 0) return 8'h00;
      v = 8'h01;
      for (int i = 1; i < k; i++) begin
         v = v[0] ? (((v ^ 8'h1D) >> 1) | 8'h80) : (v >> 1);
      end
      for (int b = 0; b < 8; b++) r[b] = v[7-b];
      return r;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // ---------------- monitor for instance A ----------------
   logic           prev_wr_a = 1'b0;
   int             wr_cnt_a, bursts_a, dones_a, seq_err_a;
   logic [7:0]     cnt_at_done_a;
   logic [7:0]     img_a [256];
   logic [DWA-1:0] exp_din_a;

   // Check every write against the expected fill/scatter stream and build the RAM image.
   always @(negedge clk) begin : mon_a
      int         pos;
      logic [7:0] ea;
      logic [7:0] ed;
      if (wr_a) begin
         if (!prev_wr_a) bursts_a++;
         if (wr_cnt_a < 256) begin
            ea = 8'(wr_cnt_a);
            ed = 8'h01;
         end else if (wr_cnt_a < 256 + N1A) begin
            pos = wr_cnt_a - 256;
            ea  = model_addr(pos);
            ed  = (exp_din_a[8*pos +: 8] == 8'h00) ? 8'h01 : 8'h00;
         end else begin
            ea = 8'h00;
            ed = 8'hFF;
         end
         if (addr_a != ea || dout_a != ed) seq_err_a++;
         img_a[addr_a] = dout_a;
         wr_cnt_a++;
      end else if (addr_a != 8'h00 || dout_a != 8'h00) begin
         seq_err_a++;
      end
      if (done_a) begin
         dones_a++;
         cnt_at_done_a = err_a;
         if (!prev_wr_a || wr_a || !busy_a) seq_err_a++;
      end
      prev_wr_a = wr_a;
   end

   // ---------------- monitor for instance B ----------------
   logic       prev_wr_b = 1'b0;
   int         wr_cnt_b, bursts_b, dones_b, seq_err_b, data_err_b;
   logic [7:0] cnt_at_done_b;
   logic [7:0] addr_log_b [128];

   // Log scatter addresses of instance B and check data/ordering on the fly.
   always @(negedge clk) begin : mon_b
      if (wr_b) begin
         if (!prev_wr_b) bursts_b++;
         if (wr_cnt_b < 128) begin
            addr_log_b[wr_cnt_b] = addr_b;
            if (addr_b != model_addr(wr_cnt_b)) seq_err_b++;
         end
         if (dout_b != 8'h00) data_err_b++;
         wr_cnt_b++;
      end
      if (done_b) begin
         dones_b++;
         cnt_at_done_b = err_b;
         if (!prev_wr_b || !busy_b) seq_err_b++;
      end
      prev_wr_b = wr_b;
   end

   task automatic clearStatsA();
      wr_cnt_a = 0; bursts_a = 0; dones_a = 0; seq_err_a = 0;
      cnt_at_done_a = 8'hEE;
      for (int i = 0; i < 256; i++) img_a[i] = 8'hEE;
   endtask

   // Start instance A with din; optionally pulse start again with din2 at wait cycle restart_at.
   task automatic applyStimulus(input logic [DWA-1:0] din, input int restart_at,
                                input logic [DWA-1:0] din2,
                                output int busy_err, output int timed_out);
      clearStatsA();
      exp_din_a = din;
      @(posedge clk); #1;
      din_a = din; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; din_a = '0;
      busy_err  = 0;
      timed_out = 1;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (done_a) begin
            timed_out = 0;
            break;
         end
         if (!busy_a) busy_err++;
         if (c == restart_at) begin
            din_a = din2; start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0; din_a = '0;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [DWA-1:0] din;
      logic [7:0]     cnt;
      int             root0;
      int             root1;
   } vec_t;

   vec_t vecs [4];

   // Full result check of one instance-A run against a table record.
   task automatic checkRunA(input string tag, input vec_t v, input int busy_err, input int timed_out);
      int ie;
      int e;
      ie = 0;
      for (int a = 0; a < 256; a++) begin
         e = (a == v.root0 || a == v.root1) ? 0 : 1;
         if (int'(img_a[a]) != e) ie++;
      end
      checkOutput({tag, " timeout"},      timed_out, 0);
      checkOutput({tag, " sequence"},     seq_err_a, 0);
      checkOutput({tag, " writes"},       wr_cnt_a, 256 + N1A);
      checkOutput({tag, " bursts"},       bursts_a, 1);
      checkOutput({tag, " dones"},        dones_a, 1);
      checkOutput({tag, " err_cnt"},      cnt_at_done_a, v.cnt);
      checkOutput({tag, " image"},        ie, 0);
      checkOutput({tag, " busy gaps"},    busy_err, 0);
      checkOutput({tag, " busy after"},   busy_a, 0);
      checkOutput({tag, " err_cnt held"}, err_a, v.cnt);
   endtask

   initial begin
      int busy_err;
      int timed_out;
      int found;

      vecs[0].din = '0;                                  vecs[0].cnt = 8'd0; vecs[0].root0 = -1;  vecs[0].root1 = -1;
      vecs[1].din = '0; vecs[1].din[8*3 +: 8] = 8'h5A;   vecs[1].cnt = 8'd1; vecs[1].root0 = 226; vecs[1].root1 = -1;
      vecs[2].din = '0; vecs[2].din[8*0 +: 8] = 8'hFF;
                        vecs[2].din[8*45 +: 8] = 8'hFF;  vecs[2].cnt = 8'd2; vecs[2].root0 = 0;   vecs[2].root1 = 77;
      vecs[3].din = '0; vecs[3].din[8*1 +: 8] = 8'h01;
                        vecs[3].din[8*2 +: 8] = 8'h80;   vecs[3].cnt = 8'd2; vecs[3].root0 = 128; vecs[3].root1 = 113;

      clearStatsA();
      wr_cnt_b = 0; bursts_b = 0; dones_b = 0; seq_err_b = 0; data_err_b = 0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset A wr/busy/done", {29'd0, wr_a, busy_a, done_a}, 0);
      checkOutput("reset A addr/dout",    {16'd0, addr_a, dout_a}, 0);
      checkOutput("reset A err_cnt",      err_a, 0);
      checkOutput("reset B outputs",      {13'd0, wr_b, busy_b, done_b, addr_b, dout_b, err_b}, 0);

      $display("[TB] table-driven runs on 128-bit pre-filling instance");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].din, -1, '0, busy_err, timed_out);
         checkRunA($sformatf("vec%0d", i), vecs[i], busy_err, timed_out);
      end

      $display("[TB] second start during FILL must be ignored");
      applyStimulus(vecs[1].din, 50, '1, busy_err, timed_out);
      checkRunA("restart", vecs[1], busy_err, timed_out);

      $display("[TB] reset at FILL cycle 100");
      clearStatsA();
      exp_din_a = '0;
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      found = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (wr_a && addr_a == 8'd100) begin
            found = 1;
            break;
         end
      end
      checkOutput("reset test reach fill 100", found, 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset mid-fill outputs", {29'd0, wr_a, busy_a, done_a}, 0);
      repeat (10) @(negedge clk);
      checkOutput("reset mid-fill no done", dones_a, 0);
      applyStimulus(vecs[0].din, -1, '0, busy_err, timed_out);
      checkRunA("after reset", vecs[0], busy_err, timed_out);

      $display("[TB] 256-bit scatter-only instance");
      wr_cnt_b = 0; bursts_b = 0; dones_b = 0; seq_err_b = 0; data_err_b = 0;
      cnt_at_done_b = 8'hEE;
      @(posedge clk); #1;
      din_b = {N1B{8'h01}}; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0; din_b = '0;
      timed_out = 1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (done_b) begin
            timed_out = 0;
            break;
         end
      end
      repeat (3) @(negedge clk);
      checkOutput("B timeout",   timed_out, 0);
      checkOutput("B writes",    wr_cnt_b, N1B);
      checkOutput("B bursts",    bursts_b, 1);
      checkOutput("B data",      data_err_b, 0);
      checkOutput("B sequence",  seq_err_b, 0);
      checkOutput("B dones",     dones_b, 1);
      checkOutput("B err_cnt",   cnt_at_done_b, 90);
      checkOutput("B addr[0]",   addr_log_b[0], 0);
      checkOutput("B addr[1]",   addr_log_b[1], 128);
      checkOutput("B addr[2]",   addr_log_b[2], 113);
      checkOutput("B addr[3]",   addr_log_b[3], 226);
      checkOutput("B addr[45]",  addr_log_b[45], 77);
      checkOutput("B addr[55]",  addr_log_b[55], 28);
      checkOutput("B addr[89]",  addr_log_b[89], 126);
      checkOutput("B busy after", busy_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
